// File: rtl/tnoc_vc_packet_arbiter.sv
// Packet-level round-robin arbiter for one output virtual channel.
// A grant is locked from header acceptance until the tail flit handshakes.
module tnoc_vc_packet_arbiter #(
  parameter int REQUESTERS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REQUESTERS-1:0] i_request,
  input  logic                  i_vc_available,
  input  logic                  i_fire,
  input  logic                  i_tail,
  output logic [REQUESTERS-1:0] o_grant,
  output logic                  o_busy
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, next_state;
  logic [REQUESTERS-1:0]   grant_q, next_grant;
  logic [PTR_W-1:0]        ptr_q, next_ptr;
  logic [PTR_W-1:0]        win_q, next_win;
  logic [PTR_W-1:0]        winner;
  logic [PTR_W-1:0]        win_plus_one;
  logic                    found;
  int                      idx;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state   <= next_state;
      grant_q <= next_grant;
      ptr_q   <= next_ptr;
      win_q   <= next_win;
    end
  end

  // Search from the pointer upward with an explicit wrap, so non power-of-2
  // requester counts never probe a nonexistent port.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!found && i_request[idx]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  assign win_plus_one = (win_q == PTR_W'(REQUESTERS - 1)) ? '0 : win_q + 1'b1;

  always_comb begin
    next_state = state;
    next_grant = grant_q;
    next_ptr   = ptr_q;
    next_win   = win_q;
    case (state)
      IDLE: begin
        next_grant = '0;
        if (found && i_vc_available) begin
          next_state = LOCKED;
          next_grant = REQUESTERS'(1) << winner;
          next_win   = winner;
        end
      end
      LOCKED: begin
        // Last winner drops to lowest priority once its packet completes.
        if (i_fire && i_tail) begin
          next_state = IDLE;
          next_grant = '0;
          next_ptr   = win_plus_one;
        end
      end
      default: begin
        next_state = IDLE;
        next_grant = '0;
      end
    endcase
  end

  always_comb begin
    o_grant = grant_q;
    o_busy  = (state == LOCKED);
  end

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_grant));
  a_busy:   assert property (@(posedge i_clk) disable iff (i_rst) o_busy == |o_grant);
  a_stable: assert property (@(posedge i_clk) disable iff (i_rst)
                             (o_busy && !(i_fire && i_tail)) |=> $stable(o_grant));
`endif

endmodule
